// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for an N-stage in-order pipeline: age-ordered hazard
// resolution, fetch drain after redirects, stall-hang watchdog and perf counters.
module pipeline_hazard_controller #(
    parameter int unsigned CORE            = 0,
    parameter int unsigned STAGES          = 7,
    parameter int unsigned FETCH_DRAIN     = 2,
    parameter int unsigned HANG_CYCLES     = 1024,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int          SCAN_CYCLES_MIN = 0,
    parameter int          SCAN_CYCLES_MAX = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [STAGES-1:0]    stall_req,
    input  logic [STAGES-1:0]    redirect_req,
    input  logic                 clog,
    input  logic                 clear_counters,
    output logic [STAGES-1:0]    stall,
    output logic [STAGES-1:0]    flush,
    output logic                 drain_active,
    output logic                 hang_error,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events,
    input  logic                 scan
);

    localparam int unsigned IDX_W   = $clog2(STAGES);
    localparam int unsigned DRAIN_W = (FETCH_DRAIN > 0) ? $clog2(FETCH_DRAIN + 1) : 1;
    localparam int unsigned HANG_W  = (HANG_CYCLES > 0) ? $clog2(HANG_CYCLES + 1) : 1;
    localparam logic        HANG_EN = (HANG_CYCLES > 0);

    logic                 s_vld;
    logic [IDX_W-1:0]     s_idx;
    logic                 r_vld;
    logic [IDX_W-1:0]     r_idx;
    logic                 redirect_acc;
    logic                 any_stall;

    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [HANG_W-1:0]    hang_cnt_q, hang_cnt_d;
    logic                 hang_error_q, hang_error_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;
    logic [31:0]          cycle_cnt_q, cycle_cnt_d;

    // Oldest stalled stage, then the oldest redirect strictly older than it
    always_comb begin
        s_vld = 1'b0;
        s_idx = '0;
        r_vld = 1'b0;
        r_idx = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (stall_req[i]) begin
                s_vld = 1'b1;
                s_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(STAGES); i++) begin
            if (redirect_req[i] && (!s_vld || (IDX_W'(i) > s_idx))) begin
                r_vld = 1'b1;
                r_idx = IDX_W'(i);
            end
        end
    end

    assign redirect_acc = !clog && r_vld;

    // Priority resolution followed by the fetch-drain overlay on stage 0
    always_comb begin
        stall = '0;
        flush = '0;
        if (clog) begin
            stall = '1;
        end else if (r_vld) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (IDX_W'(i) < r_idx) flush[i] = 1'b1;
            end
        end else if (s_vld) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (IDX_W'(i) <= s_idx)      stall[i] = 1'b1;
                if (int'(s_idx) + 1 == i)    flush[i] = 1'b1;
            end
        end
        if ((drain_cnt_q != '0) && !clog) begin
            flush[0] = 1'b1;
            stall[0] = 1'b0;
        end
    end

    assign any_stall = |stall;

    always_comb begin
        drain_cnt_d    = drain_cnt_q;
        hang_cnt_d     = hang_cnt_q;
        hang_error_d   = hang_error_q;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        cycle_cnt_d    = cycle_cnt_q + 32'd1;

        if (redirect_acc) begin
            drain_cnt_d = DRAIN_W'(FETCH_DRAIN);
        end else if (drain_cnt_q != '0) begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end

        if (!any_stall || !HANG_EN) begin
            hang_cnt_d = '0;
        end else if (hang_cnt_q != HANG_W'(HANG_CYCLES)) begin
            hang_cnt_d = hang_cnt_q + HANG_W'(1);
        end
        if (HANG_EN && (hang_cnt_d == HANG_W'(HANG_CYCLES))) begin
            hang_error_d = 1'b1;
        end

        if (clear_counters) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (any_stall && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
            end
            if (redirect_acc && (flush_events_q != '1)) begin
                flush_events_d = flush_events_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drain_cnt_q    <= '0;
            hang_cnt_q     <= '0;
            hang_error_q   <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            cycle_cnt_q    <= '0;
        end else begin
            drain_cnt_q    <= drain_cnt_d;
            hang_cnt_q     <= hang_cnt_d;
            hang_error_q   <= hang_error_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            cycle_cnt_q    <= cycle_cnt_d;
        end
    end

    assign drain_active = (drain_cnt_q != '0);
    assign hang_error   = hang_error_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

`ifndef SYNTHESIS
    // Simulation-only trace window
    always_ff @(posedge clock) begin
        if (reset && scan && (int'(cycle_cnt_q) >= SCAN_CYCLES_MIN)
                && (int'(cycle_cnt_q) <= SCAN_CYCLES_MAX)) begin
            $display("core %0d cyc %0d sreq %b rreq %b clog %b clr %b | stall %b flush %b drain %0d hang %0d err %b sc %0d fe %0d",
                     CORE, cycle_cnt_q, stall_req, redirect_req, clog, clear_counters,
                     stall, flush, drain_cnt_q, hang_cnt_q, hang_error_q,
                     stall_cycles_q, flush_events_q);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomised and directed checks of pipeline_hazard_controller against a
// cycle-level reference model built from the age-priority rules.
module tb_pipeline_hazard_controller;

    localparam int N  = 7;
    localparam int FD = 2;
    localparam int HC = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  stall_req = '0;
    logic [N-1:0]  redirect_req = '0;
    logic          clog = 1'b0;
    logic          clear_counters = 1'b0;
    logic          scan = 1'b0;
    logic [N-1:0]  stall;
    logic [N-1:0]  flush;
    logic          drain_active;
    logic          hang_error;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_drain = 0;
    int m_hang  = 0;
    int m_err   = 0;
    int m_sc    = 0;
    int m_fe    = 0;

    pipeline_hazard_controller #(
        .CORE(3), .STAGES(N), .FETCH_DRAIN(FD), .HANG_CYCLES(HC), .CNT_WIDTH(CW),
        .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(20)
    ) dut (
        .clock(clock), .reset(reset), .stall_req(stall_req), .redirect_req(redirect_req),
        .clog(clog), .clear_counters(clear_counters), .stall(stall), .flush(flush),
        .drain_active(drain_active), .hang_error(hang_error),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .scan(scan)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected controls from the oldest-stage-wins rules using mask arithmetic
    function automatic void model_comb(input logic [N-1:0] sr, input logic [N-1:0] rr,
                                       input logic cl, output logic [N-1:0] st,
                                       output logic [N-1:0] fl, output logic acc);
        int s = -1;
        int r = -1;
        for (int i = 0; i < N; i++) if (sr[i]) s = i;
        for (int i = 0; i < N; i++) if (rr[i] && i > s) r = i;
        st = '0; fl = '0; acc = 1'b0;
        if (cl) begin
            st = '1;
        end else if (r >= 0) begin
            fl  = N'((1 << r) - 1);
            acc = 1'b1;
        end else if (s >= 0) begin
            st = N'((1 << (s + 1)) - 1);
            if (s + 1 < N) fl = N'(1 << (s + 1));
        end
        if (m_drain != 0 && !cl) begin
            fl[0] = 1'b1;
            st[0] = 1'b0;
        end
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_drain"}, 32'(drain_active), 32'(m_drain != 0));
        check({tag, "_hang"},  32'(hang_error),   32'(m_err));
        check({tag, "_sc"},    32'(stall_cycles), 32'(m_sc));
        check({tag, "_fe"},    32'(flush_events), 32'(m_fe));
    endtask

    // One cycle: drive, check mid-cycle, clock, advance model
    task automatic step(input string tag, input logic [N-1:0] sr, input logic [N-1:0] rr,
                        input logic cl, input logic clr);
        logic [N-1:0] es, ef;
        logic acc;
        stall_req = sr; redirect_req = rr; clog = cl; clear_counters = clr;
        #4;
        model_comb(sr, rr, cl, es, ef, acc);
        check({tag, "_stall"}, 32'(stall), 32'(es));
        check({tag, "_flush"}, 32'(flush), 32'(ef));
        check({tag, "_excl"},  32'(stall & flush), 32'd0);
        check_regs(tag);
        @(posedge clock);
        if (acc) m_drain = FD; else if (m_drain > 0) m_drain--;
        if (es == '0) m_hang = 0; else if (m_hang < HC) m_hang++;
        if (m_hang == HC) m_err = 1;
        if (clr) begin
            m_sc = 0; m_fe = 0;
        end else begin
            if (es != '0 && m_sc < CMAX) m_sc++;
            if (acc && m_fe < CMAX) m_fe++;
        end
        #1;
    endtask

    task automatic do_reset();
        stall_req = '0; redirect_req = '0; clog = 1'b0; clear_counters = 1'b0;
        reset = 1'b0;
        m_drain = 0; m_hang = 0; m_err = 0; m_sc = 0; m_fe = 0;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check_regs("rst");
        reset = 1'b1;
    endtask

    initial begin
        scan = 1'b1;
        @(posedge clock); #1;
        do_reset();
        @(posedge clock); #1;

        // plan 1/2: idle, then held stall on stages 2..3
        step("idle", '0, '0, 0, 0);
        for (int k = 0; k < 3; k++) step("hold", 7'b0001100, '0, 0, 0);
        check("p2_sc", 32'(stall_cycles), 32'd3);
        scan = 1'b0;

        // plan 3: redirect above the stall, then fetch drain
        stall_req = 7'b0000100; redirect_req = 7'b0010010; #4;
        check("p3_stall", 32'(stall), 32'd0);
        check("p3_flush", 32'(flush), 32'(7'b0001111));
        #1; @(posedge clock); #1;
        m_drain = FD; m_sc = 3; m_fe = 1; m_hang = 0;
        check("p3_fe", 32'(flush_events), 32'd1);
        for (int k = 0; k < 2; k++) begin
            stall_req = '0; redirect_req = '0; #4;
            check("p3_drain_flush", 32'(flush), 32'd1);
            check("p3_drain_act", 32'(drain_active), 32'd1);
            #1; @(posedge clock); #1;
            m_drain--;
        end
        #4;
        check("p3_idle_flush", 32'(flush), 32'd0);
        check("p3_idle_drain", 32'(drain_active), 32'd0);
        #1; @(posedge clock); #1;

        // plan 4: redirect under a stall is ignored; clog overrides all
        stall_req = 7'b0100000; redirect_req = 7'b0001000; #4;
        check("p4_stall", 32'(stall), 32'(7'b0111111));
        check("p4_flush", 32'(flush), 32'(7'b1000000));
        #1; @(posedge clock); #1;
        m_sc++;
        check("p4_fe", 32'(flush_events), 32'd1);
        step("p4_clog", 7'b0100000, 7'b0001000, 1, 0);
        step("p4_clog_rr", '0, 7'b1000000, 1, 0);

        // plan 5: watchdog
        do_reset();
        @(posedge clock); #1;
        for (int k = 0; k < HC; k++) step("p5_hold", 7'b1000000, '0, 0, 0);
        check("p5_err", 32'(hang_error), 32'd1);
        step("p5_rel", '0, '0, 0, 0);
        step("p5_clr", '0, '0, 0, 1);
        check("p5_err_sticky", 32'(hang_error), 32'd1);

        // plan 6: saturation, then clear during a stall
        for (int k = 0; k < 20; k++) step("p6_sat", 7'b0000001, '0, 0, 0);
        check("p6_sc_sat", 32'(stall_cycles), 32'(CMAX));
        step("p6_clr", 7'b0000001, '0, 0, 1);
        check("p6_sc_zero", 32'(stall_cycles), 32'd0);

        // randomized traffic with occasional resets
        do_reset();
        @(posedge clock); #1;
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] sr, rr;
            sr = N'($urandom & $urandom & $urandom);
            rr = N'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) sr = '0;
            step("rnd", sr, rr, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                @(posedge clock); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Parametrised stall/flush controller for an N-stage in-order core. It generalises the fixed seven-stage stall unit in four ways:
- Per-stage stall and redirect request vectors are resolved by stage age.
- A fetch-drain counter discards stale I-mem responses after a redirect.
- A stall-hang watchdog flags stuck stalls.
- Saturating stall and flush performance counters.
It sits beside the pipeline registers and drives their stall/flush controls. Stage 0 is fetch issue (youngest) and stage STAGES-1 is writeback (oldest).

Parameters:
- CORE, 0, core ID printed in scan output.
- STAGES, 7, number of pipeline stages; must be at least 3.
- FETCH_DRAIN, 2, extra cycles stage 0 stays flushed after an accepted redirect; 0 disables.
- HANG_CYCLES, 1024, consecutive stalled cycles before hang_error is set; 0 disables.
- CNT_WIDTH, 32, width of the performance counters.
- SCAN_CYCLES_MIN, 0, first cycle of scan display.
- SCAN_CYCLES_MAX, 1000, last cycle of scan display.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- stall_req  in  STAGES  bit i: stage i cannot advance (data hazard, memory wait).
- redirect_req  in  STAGES  bit i: stage i resolved a control-flow redirect.
- clog  in  1  external freeze of the whole pipeline.
- clear_counters  in  1  synchronous clear of the performance counters.
- stall  out  STAGES  hold the pipeline register of stage i.
- flush  out  STAGES  insert a bubble into stage i.
- drain_active  out  1  fetch-drain counter is non-zero.
- hang_error  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with any stall bit set.
- flush_events  out  CNT_WIDTH  saturating count of accepted redirects.
- scan  in  1  enables the simulation trace.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - drain_cnt, hang_cnt, hang_error, stall_cycles, flush_events and cycle_cnt go to 0.
  - stall and flush are all 0.
  - drain_active is 0.
- **Combinational resolution (same cycle, no latency):**
  - S = highest i with stall_req[i]=1, else none.
  - R = highest i with redirect_req[i]=1 and i>S, else none. Redirects at or below S are ignored because that instruction is held.
- **Priority order:**
  1. clog=1: stall = all ones, flush = 0. Redirects are not accepted.
  2. R valid: stall = 0; flush[i]=1 for all i<R; the redirect is accepted.
  3. S valid: stall[i]=1 for i≤S; flush[S+1]=1 if S+1<STAGES.
  4. None of the above: all 0.
- **Drain overlay (applied after priority resolution):**
  - If drain_cnt≠0 and clog=0: flush[0]=1 and stall[0]=0.
  - drain_active = (drain_cnt≠0).
- **Invariant:** stall[i] and flush[i] are never both 1.
- **Drain counter:**
  - Loads FETCH_DRAIN on a cycle with an accepted redirect.
  - Otherwise decrements when non-zero; it also decrements while clog=1.
  - A new redirect reloads it (the counter restarts).
- **Watchdog:**
  - hang_cnt increments on each cycle with |stall=1 and saturates at HANG_CYCLES.
  - Any cycle with stall all zero clears hang_cnt.
  - hang_error sets on the clock edge where hang_cnt reaches HANG_CYCLES.
  - hang_error stays set until reset; clear_counters does not affect it.
  - clog-induced stall counts toward the watchdog.
- **Performance counters:**
  - stall_cycles increments on each cycle with |stall.
  - flush_events increments on each accepted redirect.
  - Both saturate at all ones.
  - clear_counters=1 zeroes both on the next edge and overrides that cycle's increment.
- **Scan:** cycle_cnt is free-running. When scan=1 and SCAN_CYCLES_MIN≤cycle_cnt≤SCAN_CYCLES_MAX, $display shows CORE, the inputs, the outputs and the counters. Scan is simulation only and has no functional effect.

Test Plan (STAGES=7, FETCH_DRAIN=2, HANG_CYCLES=8, CNT_WIDTH=4):
1. Release reset with all inputs 0 -> stall=0, flush=0, drain_active=0, hang_error=0, both counters 0.
2. stall_req=7'b0001100 -> stall=7'b0001111, flush=7'b0010000; stall_cycles increments by 1 per cycle held.
3. stall_req=7'b0000100 with redirect_req=7'b0010010 for one cycle:
   - That cycle: stall=0, flush=7'b0001111, flush_events=1.
   - Next 2 cycles (inputs 0): flush=7'b0000001, drain_active=1.
   - Third cycle: all 0.
4. stall_req=7'b0100000 with redirect_req=7'b0001000 -> redirect ignored; stall=7'b0111111, flush=7'b1000000, flush_events unchanged. Repeat with clog=1 -> stall=7'b1111111, flush=0.
5. Hold stall_req[6]=1 for 8 cycles -> hang_error=1 after the 8th edge. It stays 1 after the release and after clear_counters; reset=0 clears it.
6. Hold any stall for 20 cycles -> stall_cycles saturates at 15. Pulse clear_counters together with a stall -> stall_cycles=0 on the next edge.
